// File: rtl/dme_peak_capture.sv
`default_nettype none
// ============================================================================
//  Module   : dme_peak_capture
//  Purpose  : Multi-peak time-of-arrival capture for the DME receive path.
//             Optional X/Y pulse-pair spacing check enabled by PAIR_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module dme_peak_capture #(
   parameter int WIDTH     = 12,
   parameter int NPEAK     = 4,
   parameter int TW        = 32,
   parameter int THRESH_UP = 1100,
   parameter int THRESH_DN = 1000,
   parameter int GAP_MAX   = 4096,
   parameter int X_SPACING = 1200,
   parameter int Y_SPACING = 3600,
   parameter int TOL       = 50
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      in_data,
   output logic [NPEAK*TW-1:0]   peak_times,
   output logic [TW-1:0]         pair_spacing,
   output logic                  mode_y,
   output logic                  valid,
   output logic                  drop,
   output logic                  busy
);

   localparam int IW = (NPEAK > 1) ? $clog2(NPEAK) : 1;
   localparam int GW = $clog2(GAP_MAX + 1);

   localparam logic [WIDTH-1:0] c_thresh_up = WIDTH'(THRESH_UP);
   localparam logic [WIDTH-1:0] c_thresh_dn = WIDTH'(THRESH_DN);
   localparam logic [IW-1:0]    c_last_idx  = IW'(NPEAK - 1);
   localparam logic [GW-1:0]    c_gap_max   = GW'(GAP_MAX);
   localparam logic [TW-1:0]    c_timer_max = {TW{1'b1}};

   if (NPEAK < 2 || THRESH_DN >= THRESH_UP || GAP_MAX < 1 ||
       TOL < 0 || X_SPACING < 0 || Y_SPACING < 0) begin : g_bad_params
      $error("dme_peak_capture: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PEAK = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [WIDTH-1:0]     peak_val_q, peak_val_d;
   logic [GW-1:0]        gap_q, gap_d;
   logic [TW-1:0]        ts_q [NPEAK];
   logic [TW-1:0]        ts_d [NPEAK];
   logic [NPEAK*TW-1:0]  peak_times_q, peak_times_d;
   logic [TW-1:0]        pair_spacing_q, pair_spacing_d;
   logic                 valid_q, valid_d;
   logic                 drop_q, drop_d;
   logic [NPEAK*TW-1:0]  ts_flat;
   logic [TW-1:0]        spacing;

   for (genvar gi = 0; gi < NPEAK; gi++) begin : g_flat
      assign ts_flat[gi*TW +: TW] = ts_q[gi];
   end

   // Timestamps only ever grow, so this difference cannot underflow.
   assign spacing = ts_q[1] - ts_q[0];

`ifdef PAIR_CHECK_EN
   localparam logic [TW-1:0] c_x_spacing = TW'(X_SPACING);
   localparam logic [TW-1:0] c_y_spacing = TW'(Y_SPACING);
   localparam logic [TW-1:0] c_tol       = TW'(TOL);

   logic          mode_y_q, mode_y_d;
   logic [TW-1:0] dev_x, dev_y;

   assign dev_x = (spacing >= c_x_spacing) ? spacing - c_x_spacing : c_x_spacing - spacing;
   assign dev_y = (spacing >= c_y_spacing) ? spacing - c_y_spacing : c_y_spacing - spacing;
`endif

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      peak_val_d     = peak_val_q;
      gap_d          = gap_q;
      ts_d           = ts_q;
      peak_times_d   = peak_times_q;
      pair_spacing_d = pair_spacing_q;
      valid_d        = 1'b0;
      drop_d         = 1'b0;
`ifdef PAIR_CHECK_EN
      mode_y_d       = mode_y_q;
`endif

      if (!start) begin
         timer_d = '0;
      end else if (timer_q != c_timer_max) begin
         timer_d = timer_q + TW'(1);
      end else begin
         timer_d = timer_q;
      end

      case (state_q)
         S_IDLE: begin
            if (start && (in_data > c_thresh_up)) begin
               idx_d      = '0;
               peak_val_d = in_data;
               ts_d[0]    = timer_q;
               state_d    = S_PEAK;
            end
         end

         S_PEAK: begin
            if (!start) begin
               state_d = S_IDLE;
            end else if (in_data > peak_val_q) begin
               peak_val_d  = in_data;
               ts_d[idx_q] = timer_q;
            end else if (in_data < c_thresh_dn) begin
               if (idx_q == c_last_idx) begin
                  state_d = S_DONE;
               end else begin
                  gap_d   = '0;
                  state_d = S_WAIT;
               end
            end
         end

         S_WAIT: begin
            if (!start) begin
               state_d = S_IDLE;
            end else if (in_data > c_thresh_up) begin
               idx_d       = idx_q + IW'(1);
               peak_val_d  = in_data;
               ts_d[idx_d] = timer_q;
               state_d     = S_PEAK;
            end else if (gap_q == c_gap_max) begin
               drop_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
`ifdef PAIR_CHECK_EN
               if (dev_x <= c_tol || dev_y <= c_tol) begin
                  valid_d        = 1'b1;
                  mode_y_d       = (dev_x > c_tol);
                  peak_times_d   = ts_flat;
                  pair_spacing_d = spacing;
               end else begin
                  drop_d = 1'b1;
               end
`else
               valid_d        = 1'b1;
               peak_times_d   = ts_flat;
               pair_spacing_d = spacing;
`endif
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         timer_q        <= '0;
         idx_q          <= '0;
         peak_val_q     <= '0;
         gap_q          <= '0;
         ts_q           <= '{default: '0};
         peak_times_q   <= '0;
         pair_spacing_q <= '0;
         valid_q        <= 1'b0;
         drop_q         <= 1'b0;
`ifdef PAIR_CHECK_EN
         mode_y_q       <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         idx_q          <= idx_d;
         peak_val_q     <= peak_val_d;
         gap_q          <= gap_d;
         ts_q           <= ts_d;
         peak_times_q   <= peak_times_d;
         pair_spacing_q <= pair_spacing_d;
         valid_q        <= valid_d;
         drop_q         <= drop_d;
`ifdef PAIR_CHECK_EN
         mode_y_q       <= mode_y_d;
`endif
      end
   end

`ifdef PAIR_CHECK_EN
   assign mode_y = mode_y_q;
`else
   assign mode_y = 1'b0;
`endif

   assign peak_times   = peak_times_q;
   assign pair_spacing = pair_spacing_q;
   assign valid        = valid_q;
   assign drop         = drop_q;
   assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dme_peak_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dme_peak_capture
//  Purpose  : Directed self-checking bench for dme_peak_capture (default and
//             TW=8 instances); pair-spacing cases built only with PAIR_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dme_peak_capture;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [11:0]   in_data;

   logic [127:0]  peak_times;
   logic [31:0]   pair_spacing;
   logic          mode_y, valid, drop, busy;

   logic [31:0]   peak_times8;
   logic [7:0]    pair_spacing8;
   logic          mode_y8, valid8, drop8, busy8;

   always #5 clk = ~clk;

   dme_peak_capture dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_data      (in_data),
      .peak_times   (peak_times),
      .pair_spacing (pair_spacing),
      .mode_y       (mode_y),
      .valid        (valid),
      .drop         (drop),
      .busy         (busy)
   );

   // Narrow timer; zero X spacing so an all-saturated capture is accepted.
   dme_peak_capture #(.TW(8), .X_SPACING(0)) dut8 (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_data      (in_data),
      .peak_times   (peak_times8),
      .pair_spacing (pair_spacing8),
      .mode_y       (mode_y8),
      .valid        (valid8),
      .drop         (drop8),
      .busy         (busy8)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int c;
   int pk [4];
   int valid_cnt, drop_cnt, valid_c, drop_c, valid8_cnt, overlap_cnt;
   logic busy_at_drop;
   logic [127:0] held;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] pack4(input int a, input int b, input int e, input int f);
      return {32'(f), 32'(e), 32'(b), 32'(a)};
   endfunction

   // Triangular pulses: 1500 at the peak cycle, -100 per cycle, 900 six cycles out.
   function automatic logic [11:0] samp(input int cc);
      for (int i = 0; i < 4; i++) begin
         int d;
         d = cc - pk[i];
         if (d < 0) d = -d;
         if (d <= 6) return 12'(1500 - 100 * d);
      end
      return 12'd0;
   endfunction

   task automatic step(input logic [11:0] v);
      in_data = v;
      @(posedge clk);
      #1;
      if (valid) begin valid_cnt++; valid_c = c; end
      if (drop)  begin drop_cnt++;  drop_c  = c; busy_at_drop = busy; end
      if (valid && drop) overlap_cnt++;
      if (valid8) valid8_cnt++;
      c++;
   endtask

   task automatic clr();
      valid_cnt = 0; drop_cnt = 0; valid_c = -1; drop_c = -1;
      valid8_cnt = 0; busy_at_drop = 1'b1;
   endtask

   // One idle cycle with start low clears the timer; cycle index then tracks the timer.
   task automatic arm();
      start = 1'b0;
      step(12'd0);
      start = 1'b1;
      c = 0;
      clr();
   endtask

   task automatic run_to(input int last);
      while (c <= last) step(samp(c));
   endtask

`ifdef PAIR_CHECK_EN
   task automatic pair_case(input string tag, input int s, input logic exp_ok, input logic exp_my);
      logic [127:0] before;
      before = peak_times;
      arm();
      pk = '{100, 100 + s, 300 + s, 500 + s};
      run_to(520 + s);
      check_eq({tag, "_valid"}, 128'(valid_cnt), exp_ok ? 128'd1 : 128'd0);
      check_eq({tag, "_drop"},  128'(drop_cnt),  exp_ok ? 128'd0 : 128'd1);
      if (exp_ok) begin
         check_eq({tag, "_mode_y"}, 128'(mode_y), 128'(exp_my));
         check_eq({tag, "_spacing"}, 128'(pair_spacing), 128'(s));
      end else begin
         check_eq({tag, "_held"}, peak_times, before);
      end
   endtask
`endif

   initial begin
      overlap_cnt = 0;
      reset   = 1'b1;
      start   = 1'b0;
      in_data = 12'd0;
      c       = 0;
      clr();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_peak_times", peak_times, 128'd0);
      check_eq("rst_pair",       128'(pair_spacing), 128'd0);
      check_eq("rst_mode_y",     128'(mode_y), 128'd0);
      check_eq("rst_valid",      128'(valid),  128'd0);
      check_eq("rst_drop",       128'(drop),   128'd0);
      check_eq("rst_busy",       128'(busy),   128'd0);

      // Four-pulse train armed from cycle 0.
      reset = 1'b0;
      start = 1'b1;
      c = 0;
      pk = '{100, 1300, 5000, 6200};
      run_to(6215);
      check_eq("t1_valid_cnt", 128'(valid_cnt), 128'd1);
      check_eq("t1_valid_cyc", 128'(valid_c),   128'd6207);
      check_eq("t1_peak_times", peak_times, pack4(100, 1300, 5000, 6200));
      check_eq("t1_pair", 128'(pair_spacing), 128'd1200);
      check_eq("t1_drop_cnt", 128'(drop_cnt), 128'd0);
      check_eq("t1_busy", 128'(busy), 128'd0);
      check_eq("t1_mode_y", 128'(mode_y), 128'd0);

      // Plateau tie keeps the first maximum; hysteresis-band samples add no peak.
      arm();
      pk = '{-1000, 1211, 1300, 1400};
      while (c <= 1420) begin
         if (c == 10)                 step(12'd1200);
         else if (c == 11 || c == 12) step(12'd1400);
         else if (c == 13)            step(12'd1300);
         else if (c == 14)            step(12'd900);
         else if (c >= 15 && c <= 40) step(12'd1050);
         else                         step(samp(c));
      end
      check_eq("t2_valid_cnt", 128'(valid_cnt), 128'd1);
      check_eq("t2_valid_cyc", 128'(valid_c),   128'd1407);
      check_eq("t2_peak_times", peak_times, pack4(11, 1211, 1300, 1400));
      check_eq("t2_pair", 128'(pair_spacing), 128'd1200);

      // Gap timeout after two pulses: WAIT entered on cycle 306.
      held = peak_times;
      arm();
      pk = '{100, 300, -1000, -1000};
      run_to(4410);
      check_eq("t3_drop_cnt", 128'(drop_cnt), 128'd1);
      check_eq("t3_drop_cyc", 128'(drop_c),   128'd4403);
      check_eq("t3_valid_cnt", 128'(valid_cnt), 128'd0);
      check_eq("t3_busy_at_drop", 128'(busy_at_drop), 128'd0);
      check_eq("t3_held", peak_times, held);

      // Start dropped mid third pulse, then a fresh full train.
      arm();
      pk = '{100, 300, 500, -1000};
      run_to(500);
      check_eq("t4_busy_mid", 128'(busy), 128'd1);
      start = 1'b0;
      step(12'd0);
      check_eq("t4_busy_abort", 128'(busy), 128'd0);
      start = 1'b1;
      c = 0;
      pk = '{50, 1250, 2000, 2100};
      run_to(2115);
      check_eq("t4_valid_cnt", 128'(valid_cnt), 128'd1);
      check_eq("t4_valid_cyc", 128'(valid_c),   128'd2107);
      check_eq("t4_drop_cnt", 128'(drop_cnt), 128'd0);
      check_eq("t4_peak_times", peak_times, pack4(50, 1250, 2000, 2100));

`ifdef PAIR_CHECK_EN
      pair_case("pc_x", 1230, 1'b1, 1'b0);
      pair_case("pc_y", 3580, 1'b1, 1'b1);
      pair_case("pc_rej", 2000, 1'b0, 1'b0);
`endif

      // Narrow-timer saturation, then reset while waiting.
      arm();
      pk = '{300, 1500, 1600, 1700};
      run_to(1715);
      check_eq("t5_valid_cnt", 128'(valid_cnt), 128'd1);
      check_eq("t5_peak_times", peak_times, pack4(300, 1500, 1600, 1700));
      check_eq("t5_valid8_cnt", 128'(valid8_cnt), 128'd1);
      check_eq("t5_peak_times8", 128'(peak_times8), 128'hFFFF_FFFF);
      check_eq("t5_pair8", 128'(pair_spacing8), 128'd0);

      arm();
      pk = '{300, -1000, -1000, -1000};
      run_to(320);
      check_eq("t6_busy_wait", 128'(busy), 128'd1);
      reset = 1'b1;
      step(12'd0);
      check_eq("t6_peak_times", peak_times, 128'd0);
      check_eq("t6_pair", 128'(pair_spacing), 128'd0);
      check_eq("t6_busy", 128'(busy), 128'd0);
      check_eq("t6_valid_drop", 128'({valid, drop, mode_y}), 128'd0);
      check_eq("t6_peak_times8", 128'(peak_times8), 128'd0);
      check_eq("t6_out8", 128'({pair_spacing8, valid8, drop8, busy8, mode_y8}), 128'd0);
      reset = 1'b0;

      check_eq("valid_drop_overlap", 128'(overlap_cnt), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dme_peak_capture.md
# dme_peak_capture

Multi-peak time-of-arrival capture for the DME receive path. Watches a sampled detector stream, finds the maximum of each above-threshold excursion, and timestamps it against a free-running timer armed by `start`. After `NPEAK` peaks it publishes all timestamps and the first pair spacing in one valid pulse. It is the parametrised successor to the single-output receiver, adding gap timeout, timer saturation and optional X/Y pulse-pair checking.

## Interface
- `WIDTH`, 12: sample width (unsigned).
- `NPEAK`, 4: peaks per capture, ≥2.
- `TW`, 32: timer/timestamp width.
- `THRESH_UP`, 1100: rising threshold, strict `>`.
- `THRESH_DN`, 1000: falling threshold, strict `<`; must be less than `THRESH_UP`.
- `GAP_MAX`, 4096: maximum cycles spent in WAIT before abort.
- `X_SPACING`, 1200; `Y_SPACING`, 3600; `TOL`, 50: pair spacings in cycles (used only with PAIR_CHECK_EN).

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: arm; timer runs while high.
- `in_data` in WIDTH: detector sample, one per cycle.
- `peak_times` out NPEAK*TW: timestamp of peak i at bits [i*TW +: TW].
- `pair_spacing` out TW: `ts[1]-ts[0]`.
- `mode_y` out 1: 1 = Y-mode pair, 0 = X-mode or unchecked.
- `valid` out 1: one-cycle pulse; outputs updated in the same cycle.
- `drop` out 1: one-cycle pulse on abort (timeout or pair reject).
- `busy` out 1: high in any state other than IDLE.

## Operation
- Timer: cleared while `start`=0; increments while `start`=1; saturates at 2^TW−1 and does not wrap.
- Internal state: `peak_val`, index `idx`, timestamp array `ts[0..NPEAK-1]`, and gap counter.
- IDLE: when `start`=1 and `in_data`>THRESH_UP, set `idx`=0, `peak_val`=`in_data`, `ts[0]`=timer, and go to PEAK. When `start`=0, input is ignored.
- PEAK:
  - If `in_data`>`peak_val`, update `peak_val` and set `ts[idx]`=timer. Ties keep the earlier timestamp.
  - Otherwise, if `in_data`<THRESH_DN: go to DONE when `idx`=NPEAK−1, else go to WAIT with the gap counter cleared.
  - Samples in the hysteresis band keep the block in PEAK.
- WAIT:
  - If `in_data`>THRESH_UP: `idx`+1, `peak_val`=`in_data`, `ts[idx+1]`=timer, go to PEAK.
  - Else, if the gap counter reaches GAP_MAX: pulse `drop` and go to IDLE.
  - Otherwise increment the gap counter.
- DONE: register `peak_times` and `pair_spacing` from `ts`, pulse `valid`, go to IDLE. Exception: a pair reject under PAIR_CHECK_EN.
- `start` falling in PEAK/WAIT/DONE: go to IDLE next edge. No `valid`, no `drop`; published outputs are held.
- `pair_spacing` is an unsigned TW-bit difference. `ts` is monotonic, so there is no underflow.

## Timing
- Reset values: `peak_times`=0, `pair_spacing`=0, `mode_y`=0, `valid`=0, `drop`=0, `busy`=0, state IDLE, timer 0, `idx` 0.
- Latency: the final sub-THRESH_DN sample is clocked at edge k (enter DONE). At edge k+1, `valid`=1 and the outputs update. At edge k+2, `valid`=0.
- Timeout: `drop` is high for exactly one cycle, GAP_MAX+1 edges after WAIT entry.
- Published outputs are stable between `valid` pulses.
- `reset` overrides everything, including an in-flight DONE.
- At most one of `valid`/`drop` is high in any cycle.

## Configuration
- `PAIR_CHECK_EN` defined:
  - In DONE, set `s=ts[1]-ts[0]`.
  - If |s−X_SPACING|≤TOL: `valid`, `mode_y`=0.
  - Else if |s−Y_SPACING|≤TOL: `valid`, `mode_y`=1.
  - Else: pulse `drop` instead of `valid`, leave the outputs unchanged, go to IDLE.
- Undefined: no spacing check; every completed capture pulses `valid`; `mode_y` is tied 0.

## Test plan
- Defaults, `start`=1 from t=0. Four triangular pulses peaking at 1500 on cycles 100/1300/5000/6200, each falling to 900 → one `valid` with `peak_times`={100,1300,5000,6200}, `pair_spacing`=1200.
- Plateau: samples 1200,1400,1400,1300,900 → `ts` = the cycle of the first 1400; hysteresis samples 1050 between pulses cause no extra peak.
- After two pulses, `in_data` held at 0 → `drop` high for one cycle, GAP_MAX+1 cycles after WAIT entry; no `valid`; `busy`=0 next cycle.
- `start` dropped during the third pulse, then reasserted with a full four-pulse train → only one `valid`, with timestamps relative to the new arm.
- With PAIR_CHECK_EN, spacings 1230 → `valid`, `mode_y`=0; 3580 → `valid`, `mode_y`=1; 2000 → `drop`, outputs unchanged.
- TW=8, first peak at cycle 300 → `ts[0]`=255 (saturated); `reset` asserted in WAIT → all outputs 0 next cycle.
